// File: rtl/sum_bcd_display_pkg.sv
// Shared definitions for the sum-to-BCD display block: FSM states, segment patterns
// and the double-dabble nibble correction.
package sum_bcd_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Active-low segments, bit0 = a .. bit6 = g
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [3:0] add3_if_ge5(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

endpackage

// File: rtl/sum_bcd_display_seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern; codes 10..15 blank the digit.
module seg7_decoder
  import sum_bcd_display_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sum_bcd_display.sv
// Sequential double-dabble conversion of the adder sum into two BCD digits driving HEX1/HEX0.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks HEX1 whenever the tens digit is zero.
module sum_bcd_display
  import sum_bcd_display_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bin,
  output logic             out_valid,
  output logic [7:0]       bcd,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1
);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] HEX1_RST = SEG_BLANK;
`else
  localparam logic [6:0] HEX1_RST = SEG_0;
`endif

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [7:0]       scratch_q;
  logic [7:0]       scratch_d;
  logic [7:0]       adj_s;
  logic [2:0]       count_q;
  logic [7:0]       bcd_q;
  logic [6:0]       hex0_q;
  logic [6:0]       hex1_q;
  logic             out_valid_q;
  logic [6:0]       units_seg_s;
  logic [6:0]       tens_seg_s;
  logic [6:0]       hex1_d;

  // One double-dabble step: correct each nibble, then shift the next input bit in.
  always_comb begin
    adj_s     = {add3_if_ge5(scratch_q[7:4]), add3_if_ge5(scratch_q[3:0])};
    scratch_d = {adj_s[6:0], shreg_q[WIDTH-1]};
    shreg_d   = shreg_q << 1;
  end

  seg7_decoder u_units (
    .digit_i (scratch_d[3:0]),
    .seg_o   (units_seg_s)
  );

  seg7_decoder u_tens (
    .digit_i (scratch_d[7:4]),
    .seg_o   (tens_seg_s)
  );

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    hex1_d = (scratch_d[7:4] == 4'd0) ? SEG_BLANK : tens_seg_s;
`else
    hex1_d = tens_seg_s;
`endif
  end

  // Conversion FSM with all datapath and display registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      scratch_q   <= 8'h00;
      count_q     <= 3'd0;
      bcd_q       <= 8'h00;
      hex0_q      <= SEG_0;
      hex1_q      <= HEX1_RST;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            shreg_q   <= in_bin;
            scratch_q <= 8'h00;
            count_q   <= 3'(WIDTH);
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          scratch_q <= scratch_d;
          shreg_q   <= shreg_d;
          count_q   <= count_q - 3'd1;
          if (count_q == 3'd1) begin
            bcd_q       <= scratch_d;
            hex0_q      <= units_seg_s;
            hex1_q      <= hex1_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Ready is forced high during reset since the next edge lands in IDLE regardless
  assign in_ready  = reset | (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign bcd       = bcd_q;
  assign HEX0      = hex0_q;
  assign HEX1      = hex1_q;

endmodule

// File: tb/tb_sum_bcd_display.sv
// Scoreboard bench for sum_bcd_display: the driver queues expected results on each accept,
// a negedge monitor checks every out_valid pulse. Honours LEADING_ZERO_BLANK_EN like the RTL.
module tb_sum_bcd_display;
  localparam int WIDTH = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_bin;
  logic             out_valid;
  logic [7:0]       bcd;
  logic [6:0]       hex0;
  logic [6:0]       hex1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] bcd;
    logic [6:0] h0;
    logic [6:0] h1;
    int         acc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sum_bcd_display #(.WIDTH(WIDTH)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .bcd       (bcd),
    .HEX0      (hex0),
    .HEX1      (hex1)
  );

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_h1(input logic [3:0] t);
`ifdef LEADING_ZERO_BLANK_EN
    return (t == 4'd0) ? 7'b1111111 : seg(t);
`else
    return seg(t);
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid: got pulse with bcd %0h want none (cycle %0d)", bcd, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("bcd", 32'(bcd), 32'(mon_e.bcd));
        chk("hex0", 32'(hex0), 32'(mon_e.h0));
        chk("hex1", 32'(hex1), 32'(mon_e.h1));
        chk("latency", 32'(cyc - mon_e.acc), 32'(WIDTH));
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] v, input logic [7:0] eb, input bit hold,
                      input bit expect_out, output int acc);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_bin   = v;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready %b want 1 for value %0d", in_ready, v);
      in_valid = 1'b0;
      acc = -1;
    end else begin
      @(posedge clk);
      @(negedge clk);
      acc = cyc;
      if (expect_out) q.push_back('{eb, seg(eb[3:0]), exp_h1(eb[7:4]), acc});
      if (!hold) in_valid = 1'b0;
    end
  endtask

  initial begin
    int acc1;
    int acc2;
    int guard;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_bin   = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bcd", 32'(bcd), 32'h00);
    chk("rst_hex0", 32'(hex0), 32'(7'b1000000));
    chk("rst_hex1", 32'(hex1), 32'(exp_h1(4'd0)));
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    // 30 with single-cycle valid; busy window is SHIFT x5 + DONE
    send(5'd30, 8'h30, 1'b0, 1'b1, acc1);
    chk("busy_1", 32'(in_ready), 32'd0);
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk);
      chk("busy_n", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    chk("ready_again", 32'(in_ready), 32'd1);

    send(5'd9, 8'h09, 1'b0, 1'b1, acc1);
    send(5'd31, 8'h31, 1'b0, 1'b1, acc1);

    // Held valid: 17 then 18 after the first pulse, seven cycles apart
    send(5'd17, 8'h17, 1'b1, 1'b1, acc1);
    guard = 0;
    while (out_valid !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("held_first_pulse", 32'(out_valid), 32'd1);
    in_bin = 5'd18;
    send(5'd18, 8'h18, 1'b0, 1'b1, acc2);
    chk("held_spacing", 32'(acc2 - acc1), 32'd7);

    // Reset during the third SHIFT cycle aborts without a pulse
    send(5'd25, 8'h25, 1'b0, 1'b0, acc1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_bcd", 32'(bcd), 32'h00);
    chk("abort_hex0", 32'(hex0), 32'(7'b1000000));
    chk("abort_hex1", 32'(hex1), 32'(exp_h1(4'd0)));
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    repeat (8) @(negedge clk);

    // Exhaustive sweep with random idle gaps
    for (int v = 0; v < 32; v++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(WIDTH'(v), {4'(v / 10), 4'(v % 10)}, 1'b0, 1'b1, acc1);
    end

    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
